sram_like_arbiter: RTL

Shares the single SRAM-like memory port between the instruction-fetch requester (inst_*) and the MEM-stage data requester (data_*). It grants one address handshake per cycle and holds the grant until the slave accepts. It records the owner of each accepted request in an in-order owner FIFO, so each mem_data_ok returns to the requester that issued it. It sits between the pipeline stages and the AXI bridge.

---
 rtl/sram_like_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one SRAM-like port between fetch (inst) and MEM-stage (data) requesters
// Define ARB_RR_EN for round-robin unlocked grant; default build is fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int OUTS_DEPTH = 2,
    parameter int OUTS_CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inst_req,
    input  logic                  inst_wr,
    input  logic [1:0]            inst_size,
    input  logic [31:0]           inst_addr,
    input  logic [31:0]           inst_wdata,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [31:0]           inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [31:0]           data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [1:0]            mem_size,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [31:0]           mem_rdata,
    output logic [OUTS_CNT_W-1:0] outs_cnt,
    output logic                  arb_err
);

    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
    typedef enum logic [1:0] {ST_FREE, ST_LOCK_INST, ST_LOCK_DATA} lock_state_e;

    localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam logic [OUTS_CNT_W-1:0] FULL_CNT = OUTS_CNT_W'(OUTS_DEPTH);

    lock_state_e           state_q, state_d;
    logic [OUTS_DEPTH-1:0] own_q, own_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OUTS_CNT_W-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;

    owner_e grant;
    owner_e free_grant;
    logic   full;
    logic   push;
    logic   pop;
    logic   head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTS_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

`ifdef ARB_RR_EN
    owner_e last_q, last_d;

    // On a tie, hand the port to whoever did not win the previous accept.
    always_comb begin
        free_grant = data_req ? OWN_DATA : OWN_INST;
        if (data_req && inst_req) begin
            free_grant = (last_q == OWN_INST) ? OWN_DATA : OWN_INST;
        end
    end

    always_comb begin
        last_d = last_q;
        if (push) begin
            last_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_INST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        free_grant = data_req ? OWN_DATA : OWN_INST;
    end
`endif

    always_comb begin
        full      = (cnt_q == FULL_CNT);
        grant     = free_grant;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        state_d   = state_q;

        case (state_q)
            ST_LOCK_INST: grant = OWN_INST;
            ST_LOCK_DATA: grant = OWN_DATA;
            default:      grant = free_grant;
        endcase

        mem_req = !full && ((state_q != ST_FREE) || inst_req || data_req);

        if (mem_req) begin
            if (grant == OWN_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
            if (mem_addr_ok) begin
                state_d = ST_FREE;
            end else begin
                state_d = (grant == OWN_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
            end
        end
    end

    always_comb begin
        push         = mem_req && mem_addr_ok;
        pop          = mem_data_ok && (cnt_q != '0);
        head_data    = own_q[rptr_q];
        inst_addr_ok = push && (grant == OWN_INST);
        data_addr_ok = push && (grant == OWN_DATA);
        inst_data_ok = pop && !head_data;
        data_data_ok = pop && head_data;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
        outs_cnt     = cnt_q;
        arb_err      = err_q;

        own_d  = own_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        err_d  = err_q;

        if (push) begin
            own_d[wptr_q] = grant;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // A response with nothing outstanding is dropped but remembered.
        if (mem_data_ok && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FREE;
            own_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
